decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//   RV32I decode/operand-fetch stage directly upstream of the ALU. Accepts a fetched instruction + PC,
//   splits opcode/funct3/funct7, builds the sign-extended immediate, reads rs1/rs2 from an internal
//   32x32 register file (written by the writeback port), and presents the result in one pipeline register.
//   A valid/ready handshake on both sides provides backpressure.
// PARAMETERS
//   XLEN      32   datapath width; only 32 supported
//   NREGS     32   architectural registers; x0 reads as 0
// PORTS
//   clk          in   1     rising-edge clock
//   rst_n        in   1     asynchronous active-low reset
//   in_valid     in   1     in_instr/in_pc valid
//   in_ready     out  1     stage can accept this cycle
//   in_instr     in   32    raw instruction word
//   in_pc        in   32    PC of in_instr
//   flush        in   1     kill held output (branch redirect)
//   wb_en        in   1     writeback enable
//   wb_rd        in   5     writeback destination index
//   wb_data      in   32    writeback value
//   out_valid    out  1     decoded bundle valid
//   out_ready    in   1     ALU/execute accepts bundle
//   out_opcode   out  5     in_instr[6:2]
//   out_funct3   out  3     in_instr[14:12]
//   out_funct7   out  7     in_instr[31:25]
//   out_rs1      out  32    rs1 operand value
//   out_rs2      out  32    rs2 operand value
//   out_imm      out  32    sign-extended immediate
//   out_pc       out  32    PC of bundle
//   out_rd       out  5     in_instr[11:7]
//   out_illegal  out  1     instr[1:0]!=2'b11 or unsupported opcode
// BEHAVIOUR
// - Reset (rst_n=0, async): out_valid=0; all out_* data =0; all register-file entries =0.
// - in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
// - On accept: all out_* load on the same edge; out_valid=1 next cycle; latency 1 cycle.
// - out_valid && out_ready && !in_valid -> out_valid=0 next cycle. Held bundle stable while out_valid && !out_ready.
// - flush: out_valid=0 next cycle, priority over accept; in_ready unaffected; register-file writes still occur.
// - Regfile write: posedge, when wb_en && wb_rd!=0. wb_rd=0 ignored; x0 always reads 0.
// - Read bypass: on accept, if wb_en && wb_rd!=0 && wb_rd==rsN index -> out_rsN = wb_data (same-cycle forward).
// - Held-operand refresh: while out_valid && !out_ready, if wb_en && wb_rd!=0 && wb_rd==held rsN index -> out_rsN
//   updated to wb_data. Held rs1/rs2 indices are therefore stored internally.
// - Immediate by opcode (instr[6:2]):
//     00100 OP-IMM, 00000 LOAD, 11001 JALR : I = sext(instr[31:20])
//     01000 STORE  : S = sext({instr[31:25],instr[11:7]})
//     11000 BRANCH : B = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
//     01101 LUI, 00101 AUIPC : U = {instr[31:12],12'b0}
//     11011 JAL    : J = sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
//     01100 OP     : imm = 0
//     other        : imm = 0, out_illegal=1
// - Shift-imm: imm is plain I-type; imm[5]=instr[25] is passed through for the execute stage to check.
// - Illegal instructions still flow with out_illegal=1; no stall, no regfile side effects.
// TESTING
// - Reset mid-bundle: out_valid=1 then rst_n=0 -> out_valid=0, out_rs1=0 immediately (async).
// - Write x5=0x0000_1234, then decode addi x6,x5,-1 (0xFFF28313) -> out_rs1=0x1234, out_imm=0xFFFF_FFFF, opcode=00100.
// - Same-cycle bypass: wb x7=0xDEAD_BEEF while accepting add x1,x7,x0 -> out_rs1=0xDEADBEEF, out_rs2=0.
// - Backpressure: out_ready=0 for 3 cycles, wb x7=5 meanwhile -> in_ready=0, bundle held, out_rs1 becomes 5.
// - Immediates: lui 0x12345 -> 0x1234_5000; beq offset -4 -> 0xFFFF_FFFC; sw offset 8 -> 0x0000_0008.
// - Write to x0 with 0xFFFF_FFFF then read x0 -> 0; instr 0x0000_0000 -> out_illegal=1; flush+accept -> out_valid=0.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode / operand-fetch stage feeding the ALU.
// Splits the instruction fields, builds the sign-extended immediate, reads rs1/rs2
// from an internal register file, and holds the result in one pipeline register
// with valid/ready handshakes on both sides.
//
// Ports
//   clk, rst_n                         clock, asynchronous active-low reset
//   in_valid/in_ready                  upstream handshake (in_ready is combinational)
//   in_instr, in_pc                    fetched instruction and its PC
//   flush                              kill the held bundle and any bundle arriving this cycle
//   wb_en, wb_rd, wb_data              register-file write port (x0 writes ignored)
//   out_valid/out_ready                downstream handshake
//   out_opcode/funct3/funct7/rd        raw instruction fields
//   out_rs1, out_rs2                   operand values (bypassed / refreshed from writeback)
//   out_imm                            sign-extended immediate for the opcode format
//   out_pc                             PC of the bundle
//   out_illegal                        non-32-bit encoding or unsupported opcode
module decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    logic [XLEN-1:0] rf [NREGS];
    logic [4:0]      hold_rs1;
    logic [4:0]      hold_rs2;

    logic            accept;
    logic            wb_act;
    logic [4:0]      rs1_idx;
    logic [4:0]      rs2_idx;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm_val;
    logic            illegal_val;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign wb_act   = wb_en && (wb_rd != 5'd0);
    assign rs1_idx  = in_instr[19:15];
    assign rs2_idx  = in_instr[24:20];

    // Operand read with same-cycle forwarding from the writeback port.
    always_comb begin
        rs1_val = rf[rs1_idx];
        rs2_val = rf[rs2_idx];
        if (wb_act && (wb_rd == rs1_idx)) rs1_val = wb_data;
        if (wb_act && (wb_rd == rs2_idx)) rs2_val = wb_data;
        if (rs1_idx == 5'd0) rs1_val = '0;
        if (rs2_idx == 5'd0) rs2_val = '0;
    end

    // Immediate format selection; unknown opcodes decode as illegal with a zero immediate.
    always_comb begin
        imm_val     = '0;
        illegal_val = (in_instr[1:0] != 2'b11);
        case (in_instr[6:2])
            OPC_OPIMM, OPC_LOAD, OPC_JALR:
                imm_val = {{20{in_instr[31]}}, in_instr[31:20]};
            OPC_STORE:
                imm_val = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            OPC_BRANCH:
                imm_val = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm_val = {in_instr[31:12], 12'b0};
            OPC_JAL:
                imm_val = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            OPC_OP:
                imm_val = '0;
            default: begin
                imm_val     = '0;
                illegal_val = 1'b1;
            end
        endcase
    end

    // Register file; entry 0 is never written so x0 stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) rf[i] <= '0;
        end else if (wb_act) begin
            rf[wb_rd] <= wb_data;
        end
    end

    // Output pipeline register: load on accept, refresh held operands on writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_opcode  <= '0;
            out_funct3  <= '0;
            out_funct7  <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_imm     <= '0;
            out_pc      <= '0;
            out_rd      <= '0;
            out_illegal <= 1'b0;
            hold_rs1    <= '0;
            hold_rs2    <= '0;
        end else begin
            if (flush)          out_valid <= 1'b0;
            else if (accept)    out_valid <= 1'b1;
            else if (out_ready) out_valid <= 1'b0;

            if (accept && !flush) begin
                out_opcode  <= in_instr[6:2];
                out_funct3  <= in_instr[14:12];
                out_funct7  <= in_instr[31:25];
                out_rd      <= in_instr[11:7];
                out_rs1     <= rs1_val;
                out_rs2     <= rs2_val;
                out_imm     <= imm_val;
                out_pc      <= in_pc;
                out_illegal <= illegal_val;
                hold_rs1    <= rs1_idx;
                hold_rs2    <= rs2_idx;
            end else if (out_valid && !out_ready) begin
                // A stalled bundle must not carry operands made stale by a later writeback.
                if (wb_act && (wb_rd == hold_rs1)) out_rs1 <= wb_data;
                if (wb_act && (wb_rd == hold_rs2)) out_rs2 <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios followed by random traffic, all
// checked by a scoreboard against an architectural model of decode + register file.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [31:0] out_rs1;
    logic [31:0] out_rs2;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic        out_illegal;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_pc(out_pc),
        .out_rd(out_rd), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    logic [31:0] rf [32];
    int          n_total = 0;
    int          n_pass  = 0;

    logic        pend_acc = 1'b0;
    logic [31:0] pend_ins;
    logic [31:0] pend_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Architectural decode: fields and immediate derived from the ISA formats.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        logic signed [11:0] i12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        e.opcode = ins[6:2];
        e.f3     = ins[14:12];
        e.f7     = ins[31:25];
        e.rd     = ins[11:7];
        e.rs1    = ins[19:15];
        e.rs2    = ins[24:20];
        e.pc     = pc;
        e.ill    = (ins[1:0] != 2'b11);
        e.imm    = 32'd0;
        case (ins[6:2])
            5'b00100, 5'b00000, 5'b11001: begin i12 = ins[31:20]; e.imm = int'(i12); end
            5'b01000: begin i12 = {ins[31:25], ins[11:7]}; e.imm = int'(i12); end
            5'b11000: begin b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; e.imm = int'(b13); end
            5'b01101, 5'b00101: e.imm = ins & 32'hFFFF_F000;
            5'b11011: begin j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; e.imm = int'(j21); end
            5'b01100: e.imm = 32'd0;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int unsigned sel;
        w   = $urandom;
        sel = $urandom_range(0, 11);
        case (sel)
            0: w[6:2] = 5'b00100;
            1: w[6:2] = 5'b00000;
            2: w[6:2] = 5'b11001;
            3: w[6:2] = 5'b01000;
            4: w[6:2] = 5'b11000;
            5: w[6:2] = 5'b01101;
            6: w[6:2] = 5'b00101;
            7: w[6:2] = 5'b11011;
            8: w[6:2] = 5'b01100;
            10: w[6:2] = 5'b11100;
            11: w[6:2] = 5'b00100;
            default: ;
        endcase
        if (sel != 9 && sel != 11) w[1:0] = 2'b11;
        if ($urandom_range(0, 1) == 1) begin
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
        end
        return w;
    endfunction

    // One clock of stimulus: drive after the rising edge, record acceptance at the falling edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic rdy, input logic fl, input logic we,
                        input logic [4:0] wrd, input logic [31:0] wd);
        @(posedge clk);
        #1;
        if (pend_acc) q.push_back(model(pend_ins, pend_pc));
        pend_acc  = 1'b0;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        wb_en     = we;
        wb_rd     = wrd;
        wb_data   = wd;
        @(negedge clk);
        pend_acc = v && in_ready && !fl;
        pend_ins = ins;
        pend_pc  = pc;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0000_0013, 32'd0, rdy, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    // Scoreboard monitor: operands must equal the architectural register values at hand-off.
    always @(negedge clk) begin
        if (rst_n) begin
            logic exp_v;
            exp_t e;
            exp_v = (q.size() != 0);
            chk("out_valid", 32'(out_valid), 32'(exp_v));
            chk("in_ready", 32'(in_ready), 32'(!exp_v || out_ready));
            if (exp_v && out_ready) begin
                e = q.pop_front();
                chk("opcode", 32'(out_opcode), 32'(e.opcode));
                chk("funct3", 32'(out_funct3), 32'(e.f3));
                chk("funct7", 32'(out_funct7), 32'(e.f7));
                chk("rd", 32'(out_rd), 32'(e.rd));
                chk("imm", out_imm, e.imm);
                chk("pc", out_pc, e.pc);
                chk("illegal", 32'(out_illegal), 32'(e.ill));
                chk("rs1", out_rs1, rf[e.rs1]);
                chk("rs2", out_rs2, rf[e.rs2]);
            end else if (exp_v && flush) begin
                void'(q.pop_front());
            end
            if (wb_en && wb_rd != 5'd0) rf[wb_rd] = wb_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0; flush = 1'b0;
        wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; out_ready = 1'b0;
        #12;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_rs1", out_rs1, 32'd0);
        chk("reset_out_imm", out_imm, 32'd0);
        chk("reset_out_pc", out_pc, 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        #1 rst_n = 1'b1;

        // addi x6,x5,-1 after writing x5
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_1234);
        step(1'b1, 32'hFFF2_8313, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        idle(1'b1);
        chk("addi_rs1", out_rs1, 32'h0000_1234);
        chk("addi_imm", out_imm, 32'hFFFF_FFFF);
        chk("addi_opcode", 32'(out_opcode), 32'h04);

        // same-cycle bypass: add x1,x7,x0 while x7 is written
        step(1'b1, 32'h0003_80B3, 32'h0000_0104, 1'b1, 1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF);
        idle(1'b1);
        chk("bypass_rs1", out_rs1, 32'hDEAD_BEEF);
        chk("bypass_rs2", out_rs2, 32'd0);

        // backpressure: addi x2,x7,0 held three cycles, x7 rewritten meanwhile
        step(1'b1, 32'h0003_8113, 32'h0000_0108, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 32'h0000_0013, 32'h0000_010C, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("bp_in_ready_1", 32'(in_ready), 32'd0);
        step(1'b1, 32'h0000_0013, 32'h0000_010C, 1'b0, 1'b0, 1'b1, 5'd7, 32'd5);
        chk("bp_in_ready_2", 32'(in_ready), 32'd0);
        step(1'b1, 32'h0000_0013, 32'h0000_010C, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("bp_in_ready_3", 32'(in_ready), 32'd0);
        chk("bp_held_pc", out_pc, 32'h0000_0108);
        chk("bp_refresh_rs1", out_rs1, 32'd5);
        idle(1'b1);

        // immediates: lui, beq -4, sw 8
        step(1'b1, 32'h1234_51B7, 32'h0000_0200, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 32'hFE00_0EE3, 32'h0000_0204, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("lui_imm", out_imm, 32'h1234_5000);
        step(1'b1, 32'h0020_2423, 32'h0000_0208, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("beq_imm", out_imm, 32'hFFFF_FFFC);
        idle(1'b1);
        chk("sw_imm", out_imm, 32'h0000_0008);

        // x0 stays zero, all-zero word is illegal
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        step(1'b1, 32'h0000_00B3, 32'h0000_0300, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 32'h0000_0000, 32'h0000_0304, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        chk("x0_rs1", out_rs1, 32'd0);
        chk("x0_rs2", out_rs2, 32'd0);
        idle(1'b1);
        chk("zero_word_illegal", 32'(out_illegal), 32'd1);

        // flush beats accept; flush also kills a stalled bundle
        step(1'b1, 32'h0000_0013, 32'h0000_0400, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        idle(1'b1);
        chk("flush_accept_valid", 32'(out_valid), 32'd0);
        step(1'b1, 32'h0000_0013, 32'h0000_0404, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b0, 32'h0000_0013, 32'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        idle(1'b0);
        chk("flush_held_valid", 32'(out_valid), 32'd0);

        // asynchronous reset while a bundle is held
        step(1'b1, 32'h0003_8113, 32'h0000_0500, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        idle(1'b0);
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 32'(out_valid), 32'd0);
        chk("async_reset_rs1", out_rs1, 32'd0);
        q.delete();
        pend_acc = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;

        // random traffic
        for (int k = 0; k < 2000; k++) begin
            step($urandom_range(0, 9) < 7, rand_instr(), $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
